// File: rtl/mem_access_unit_if.sv
`timescale 1ns/1ps
// Request/response and system-bus signal group for mem_access_unit.
// slave = the unit itself; master = execute stage plus bus slave.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_error;
    logic [31:0] rsp_rdata;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_bwe;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_wait;

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, bus_rdata, bus_wait,
        output req_ready, rsp_valid, rsp_error, rsp_rdata,
        output bus_read, bus_write, bus_bwe, bus_addr, bus_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, bus_rdata, bus_wait,
        input  req_ready, rsp_valid, rsp_error, rsp_rdata,
        input  bus_read, bus_write, bus_bwe, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// Single-outstanding load/store sequencer, big-endian lanes,
// with alignment check, bus stall hold and wait timeout.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic            clk,
    input logic            reset_n,
    mem_access_unit_if.slave mif
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] off;
    } req_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [1:0]  rsp_error_q, rsp_error_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        bus_read_q, bus_read_d;
    logic        bus_write_q, bus_write_d;
    logic [3:0]  bus_bwe_q, bus_bwe_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    function automatic logic misaligned(logic [1:0] sz, logic [1:0] off);
        unique case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off;
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lanes(logic [1:0] sz, logic [1:0] off);
        unique case (sz)
            2'b00:   lanes = 4'b1000 >> off;
            2'b01:   lanes = off[1] ? 4'b0011 : 4'b1100;
            default: lanes = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] place(logic [1:0] sz, logic [31:0] w);
        unique case (sz)
            2'b00:   place = {4{w[7:0]}};
            2'b01:   place = {2{w[15:0]}};
            default: place = w;
        endcase
    endfunction

    // Pick the addressed lane(s) and extend to a full word.
    function automatic logic [31:0] load_ext(logic [31:0] rd, req_t r);
        logic [7:0]  b;
        logic [15:0] h;
        unique case (r.off)
            2'd0: b = rd[31:24];
            2'd1: b = rd[23:16];
            2'd2: b = rd[15:8];
            2'd3: b = rd[7:0];
        endcase
        h = r.off[1] ? rd[15:0] : rd[31:16];
        unique case (r.size)
            2'b00:   load_ext = {{24{r.sgn & b[7]}}, b};
            2'b01:   load_ext = {{16{r.sgn & h[15]}}, h};
            default: load_ext = rd;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_error_d = 2'b00;
        rsp_rdata_d = 32'd0;
        bus_read_d  = 1'b0;
        bus_write_d = 1'b0;
        bus_bwe_d   = 4'b0000;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (mif.req_valid) begin
                    req_ready_d = 1'b0;
                    req_d.write = mif.req_write;
                    req_d.size  = mif.req_size;
                    req_d.sgn   = mif.req_signed;
                    req_d.off   = mif.req_addr[1:0];
                    bus_addr_d  = {mif.req_addr[31:2], 2'b00};
                    bus_wdata_d = place(mif.req_size, mif.req_wdata);
                    if (misaligned(mif.req_size, mif.req_addr[1:0])) begin
                        state_d     = ERR;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 2'b01;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = 16'd0;
                        bus_read_d  = ~mif.req_write;
                        bus_write_d = mif.req_write;
                        if (mif.req_write)
                            bus_bwe_d = lanes(mif.req_size, mif.req_addr[1:0]);
                    end
                end
            end
            ACCESS: begin
                if (!mif.bus_wait) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    if (!req_q.write)
                        rsp_rdata_d = load_ext(mif.bus_rdata, req_q);
                end else if (cnt_q == TO_LIM) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 2'b10;
                end else begin
                    cnt_d       = cnt_q + 16'd1;
                    bus_read_d  = bus_read_q;
                    bus_write_d = bus_write_q;
                    bus_bwe_d   = bus_bwe_q;
                end
            end
            RESP, ERR: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= 16'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 2'b00;
            rsp_rdata_q <= 32'd0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_bwe_q   <= 4'b0000;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            bus_bwe_q   <= bus_bwe_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign mif.req_ready = req_ready_q;
    assign mif.rsp_valid = rsp_valid_q;
    assign mif.rsp_error = rsp_error_q;
    assign mif.rsp_rdata = rsp_rdata_q;
    assign mif.bus_read  = bus_read_q;
    assign mif.bus_write = bus_write_q;
    assign mif.bus_bwe   = bus_bwe_q;
    assign mif.bus_addr  = bus_addr_q;
    assign mif.bus_wdata = bus_wdata_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the CPU execute stage and the system bus. Accepts one byte/word/dword memory request at a time, checks alignment, and drives the bus control group (read, write, 4-bit byte write enable) with lane-placed write data. Holds the access while the bus stalls, aborts on timeout, and returns aligned, sign- or zero-extended load data with a one-cycle response strobe. Big-endian lane order throughout: byte offset 0 is bits [31:24], and bwe bit 3 maps to byte offset 0.

## Interface
- TIMEOUT_CYCLES, 255: maximum consecutive bus_wait cycles before abort; legal range 1..65535.
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 word (16 b), 10 dword (32 b); 11 treated as misaligned.
- req_signed  in  1  sign-extend the load result.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_error  out  2  00 ok, 01 misaligned/illegal size, 10 bus timeout; valid with rsp_valid.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- bus_read  out  1  read strobe.
- bus_write  out  1  write strobe.
- bus_bwe  out  4  byte write enables; 0000 unless bus_write.
- bus_addr  out  32  req_addr with bits [1:0] forced to 00.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data; sampled on the completing cycle.
- bus_wait  in  1  slave stall; access completes on the first ACCESS cycle with bus_wait=0.

## Operation
- States: IDLE, ACCESS, RESP, ERR.
- IDLE: req_ready=1. On req_valid, register the request.
  - Misaligned (word with addr[0]=1, dword with addr[1:0]≠00, or size 11): go to ERR.
  - Otherwise: go to ACCESS and clear the wait counter.
- ACCESS: bus outputs held constant. While bus_wait=1, increment the 16-bit wait counter. If the counter reaches TIMEOUT_CYCLES, go to RESP with error 10; no data is captured.
- ACCESS with bus_wait=0: the access completes. Capture the extracted read data and go to RESP with error 00.
- RESP/ERR: rsp_valid=1 for exactly one cycle, then go to IDLE. ERR drives error 01 and never asserts a bus strobe.
- Store bwe by size and offset:
  - Byte: offset 0→1000, 1→0100, 2→0010, 3→0001.
  - Word: offset 0→1100, offset 2→0011.
  - Dword: 1111.
- Store wdata:
  - Byte: {4{wdata[7:0]}}.
  - Word: {2{wdata[15:0]}}.
  - Dword: passed through.
- Load extraction:
  - Byte at offset k: bus_rdata[31-8k -: 8].
  - Word at offset 0: [31:16]; at offset 2: [15:0].
  - Extend to 32 bits: sign-extend when req_signed=1, otherwise zero-extend.
- Loads drive bus_read=1, bus_write=0, bwe=0000. Stores drive bus_read=0, bus_write=1.
- req_valid while not in IDLE is ignored (req_ready=0). No request queuing.

## Timing
- All outputs are registered.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_error=00, rsp_rdata=0, bus_read=0, bus_write=0, bus_bwe=0000, bus_addr=0, bus_wdata=0, wait counter=0.
- Reset asserted mid-access drops the strobes immediately and returns the unit to IDLE; no response is issued.
- Cycle 0: request accepted. Cycle 1: strobes high. For a zero-wait access, cycle 1 completes and rsp_valid is high in cycle 2. Each wait cycle adds one cycle.
- Strobes deassert in the same cycle rsp_valid rises. req_ready returns in the cycle after rsp_valid, so back-to-back requests are accepted every 3 cycles minimum.
- Misaligned request: rsp_valid in cycle 1, no bus activity.
- Timeout: with bus_wait stuck high, rsp_valid rises in cycle TIMEOUT_CYCLES+2.
- If bus_wait falls on the same cycle the counter would hit the limit, completion wins and error is 00.

## Test plan
- Byte store: addr 0x1001, wdata 0xAB -> bus_addr 0x1000, bwe 0100, wdata 0xABABABAB, rsp_valid at cycle 2, error 00.
- Signed byte load: addr 0x2003, bus_rdata 0x123456F0 -> rsp_rdata 0xFFFFFFF0. Same access unsigned -> 0x000000F0.
- Word load at offset 2 with bus_wait high for 3 cycles: rdata 0xDEAD8001 -> strobe held for 4 cycles, rsp_rdata 0x00008001 (unsigned), rsp_valid at cycle 5.
- Misaligned dword: addr 0x3002 -> no strobe, rsp_valid at cycle 1, error 01, rdata 0.
- Timeout with TIMEOUT_CYCLES=4 and bus_wait stuck high -> rsp_valid at cycle 6, error 10. Then a dword store 0x11223344 -> bwe 1111, error 00.
- reset_n pulsed low during ACCESS -> strobes 0 immediately, no rsp_valid, req_ready=1 after release.
